// File: rtl/sync_fifo_if.sv
// sync_fifo_if: control/data bundle for sync_fifo (en/rw/addr/in/out plus
// empty/full status). The master side drives a request and the FIFO side
// answers with data and status.
//
// Request semantics (the only handshake on this bus):
//   - A request exists when en=1. rw selects push (1) or pop (0), never both.
//   - The producer may push in any cycle where full=0, and the consumer may pop
//     in any cycle where empty=0. Both actions take effect at the next rising
//     clock edge.
//   - A push while full=1 or a pop while empty=1 is dropped silently. There is
//     no stall and no error flag, so the requester must watch full/empty.
//   - empty/full describe the state before the coming edge. This lets a
//     requester check them in the same cycle it raises en.
interface sync_fifo_if #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = $clog2(SIZE);

    logic                  en;
    logic                  rw;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] in;
    logic [DATA_WIDTH-1:0] out;
    logic                  empty;
    logic                  full;

    modport master (
        output en, rw, addr, in,
        input  out, empty, full
    );

    modport slave (
        input  en, rw, addr, in,
        output out, empty, full
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a RAM-like control port.
//   - SIZE entries (a power of two, >= 2) of DATA_WIDTH bits. The pointers wrap
//     naturally modulo SIZE.
//   - FALL_THROUGH=1: out shows the head combinationally. If the FIFO is empty
//     and a push is requested, in is bypassed to out in the same cycle.
//   - FALL_THROUGH=0: out is registered. It loads the head on each pop edge
//     and holds that value otherwise.
//   - Optional macro SYNC_FIFO_PEEK_EN: while en=0, out shows the entry at
//     offset addr from the head, or 0 when addr >= count. This is read-only
//     and never moves a pointer.
//   - rst is asynchronous and active-high. It clears the pointers, the count
//     and the registered output. The storage array itself is never cleared.
module sync_fifo #(
    parameter int SIZE         = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int FALL_THROUGH = 0
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  is_empty;
    logic                  is_full;
    logic                  do_push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] head_word;
    logic [DATA_WIDTH-1:0] normal_out;

    // Status is a pure decode of count, so it settles the cycle after each edge.
    assign is_empty  = (count == '0);
    assign is_full   = (count == CW'(SIZE));
    assign bus.empty = is_empty;
    assign bus.full  = is_full;

    // rw picks exactly one action. Illegal requests (push when full, pop when
    // empty) are filtered out here, so they cannot disturb any state below.
    assign do_push = bus.en &&  bus.rw && !is_full;
    assign do_pop  = bus.en && !bus.rw && !is_empty;

    // Storage write port; the array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.in;
        end
    end

    // Pointer and occupancy bookkeeping; reset drops all contents at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                count <= count + 1'b1;
            end else if (do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Current head entry, read asynchronously from the array.
    always_comb begin
        head_word = mem[rd_ptr];
    end

    generate
        if (FALL_THROUGH != 0) begin : g_fall_through
            // Head when occupied; same-cycle bypass of a push into an empty FIFO.
            always_comb begin
                normal_out = '0;
                if (!is_empty) begin
                    normal_out = head_word;
                end else if (bus.en && bus.rw) begin
                    normal_out = bus.in;
                end
            end
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] out_q;

            // Capture the departing head on each pop; hold the value otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (do_pop) begin
                    out_q <= head_word;
                end
            end

            // Registered value presented as the normal output.
            always_comb begin
                normal_out = out_q;
            end
        end
    endgenerate

`ifdef SYNC_FIFO_PEEK_EN
    logic [AW-1:0]         peek_idx;
    logic                  peek_hit;
    logic [DATA_WIDTH-1:0] peek_word;

    // Peek at offset addr from the head; offsets past the occupancy read as 0.
    always_comb begin
        peek_idx  = rd_ptr + bus.addr;
        peek_hit  = ({1'b0, bus.addr} < count);
        peek_word = '0;
        if (peek_hit) begin
            peek_word = mem[peek_idx];
        end
    end

    // Peek only takes over the output while no operation is requested.
    always_comb begin
        bus.out = normal_out;
        if (!bus.en) begin
            bus.out = peek_word;
        end
    end
`else
    // Without peek, addr has no function; fold it into a sink net.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.addr};

    // Output follows the selected fall-through/registered mode at all times.
    always_comb begin
        bus.out = normal_out;
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: runs a fall-through instance and a registered-output instance
// of sync_fifo side by side, with identical stimulus on both. A queue model
// holds the expected FIFO contents. From it the bench derives the expected
// out, empty and full of each instance.
module tb_sync_fifo;
    localparam int SIZE = 16;
    localparam int DW   = 4;
    localparam int AW   = $clog2(SIZE);

    logic clk;
    logic rst;

    sync_fifo_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) ift ();
    sync_fifo_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) irg ();

    sync_fifo #(.SIZE(SIZE), .DATA_WIDTH(DW), .FALL_THROUGH(1)) dut_ft (
        .clk(clk), .rst(rst), .bus(ift)
    );
    sync_fifo #(.SIZE(SIZE), .DATA_WIDTH(DW), .FALL_THROUGH(0)) dut_rg (
        .clk(clk), .rst(rst), .bus(irg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rg_exp;
    logic          cur_en, cur_rw;
    logic [DW-1:0] cur_in;
    logic [AW-1:0] cur_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Expected fall-through output for the current inputs and contents.
    function automatic logic [DW-1:0] exp_ft();
`ifdef SYNC_FIFO_PEEK_EN
        if (!cur_en) return (int'(cur_addr) < exp_q.size()) ? exp_q[int'(cur_addr)] : '0;
`endif
        if (exp_q.size() != 0) return exp_q[0];
        if (cur_en && cur_rw) return cur_in;
        return '0;
    endfunction

    // Expected registered output: the last popped word, unless peek applies.
    function automatic logic [DW-1:0] exp_rg();
`ifdef SYNC_FIFO_PEEK_EN
        if (!cur_en) return (int'(cur_addr) < exp_q.size()) ? exp_q[int'(cur_addr)] : '0;
`endif
        return rg_exp;
    endfunction

    // driver: same request on both instances
    task automatic drive(input logic e, input logic w, input logic [DW-1:0] d,
                         input logic [AW-1:0] a = '0);
        cur_en = e; cur_rw = w; cur_in = d; cur_addr = a;
        ift.en = e; ift.rw = w; ift.in = d; ift.addr = a;
        irg.en = e; irg.rw = w; irg.in = d; irg.addr = a;
    endtask

    // One clock edge; the model applies the request that was held across it.
    task automatic tick();
        @(posedge clk);
        if (cur_en && cur_rw && exp_q.size() < SIZE) exp_q.push_back(cur_in);
        else if (cur_en && !cur_rw && exp_q.size() > 0) rg_exp = exp_q.pop_front();
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        rg_exp = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty_ft: got %b want 1", ift.empty); end
        n_checks++; if (irg.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty_rg: got %b want 1", irg.empty); end
        n_checks++; if (ift.full !== 1'b0) begin n_errors++; $display("FAIL reset_full_ft: got %b want 0", ift.full); end
        n_checks++; if (irg.out !== 4'd0) begin n_errors++; $display("FAIL reset_out_rg: got %0h want 0", irg.out); end
        // pop on empty must be ignored
        drive(1'b1, 1'b0, 4'hA);
        #1;
        n_checks++; if (ift.out !== 4'd0) begin n_errors++; $display("FAIL pop_empty_out_ft: got %0h want 0", ift.out); end
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL pop_empty_stays_empty: got %b want 1", ift.empty); end
        n_checks++; if (ift.full !== 1'b0) begin n_errors++; $display("FAIL pop_empty_full: got %b want 0", ift.full); end
        n_checks++; if (ift.out !== exp_ft()) begin n_errors++; $display("FAIL pop_empty_idle_ft: got %0h want %0h", ift.out, exp_ft()); end
        n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL pop_empty_idle_rg: got %0h want %0h", irg.out, exp_rg()); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 4'd1);
        #1;
        n_checks++; if (ift.out !== 4'd1) begin n_errors++; $display("FAIL bypass_same_cycle: got %0h want 1", ift.out); end
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL bypass_empty_before_edge: got %b want 1", ift.empty); end
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        n_checks++; if (ift.empty !== 1'b0) begin n_errors++; $display("FAIL bypass_empty_after: got %b want 0", ift.empty); end
        n_checks++; if (ift.out !== 4'd1) begin n_errors++; $display("FAIL bypass_head_after: got %0h want 1", ift.out); end
        n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL bypass_rg_hold: got %0h want %0h", irg.out, exp_rg()); end
    endtask

    task automatic test_pop_to_empty();
        drive(1'b1, 1'b0, '0);
        #1;
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL pop_to_empty_flag: got %b want 1", ift.empty); end
        n_checks++; if (ift.out !== 4'd0) begin n_errors++; $display("FAIL pop_to_empty_out_ft: got %0h want 0", ift.out); end
        n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL pop_to_empty_out_rg: got %0h want %0h", irg.out, exp_rg()); end
    endtask

    // Fill to full, drop a push on full, drain in order. Run twice so the
    // pointers wrap around the array.
    task automatic test_fill_full();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < SIZE; i++) begin
                logic [DW-1:0] v;
                v = (pass == 0) ? DW'(i) : DW'($urandom_range(0, 15));
                drive(1'b1, 1'b1, v);
                #1;
                n_checks++; if (ift.full !== 1'b0) begin n_errors++; $display("FAIL fill_full_early p%0d i%0d: got %b want 0", pass, i, ift.full); end
                tick();
            end
            drive(1'b0, 1'b0, '0);
            #1;
            n_checks++; if (ift.full !== 1'b1) begin n_errors++; $display("FAIL fill_full_flag p%0d: got %b want 1", pass, ift.full); end
            n_checks++; if (irg.full !== 1'b1) begin n_errors++; $display("FAIL fill_full_flag_rg p%0d: got %b want 1", pass, irg.full); end
            drive(1'b1, 1'b1, 4'd9);
            #1;
            tick();
            for (int i = 0; i < SIZE; i++) begin
                drive(1'b1, 1'b0, '0);
                #1;
                n_checks++; if (ift.out !== exp_q[0]) begin n_errors++; $display("FAIL drain_head_ft p%0d i%0d: got %0h want %0h", pass, i, ift.out, exp_q[0]); end
                if (pass == 0) begin
                    n_checks++; if (ift.out !== DW'(i)) begin n_errors++; $display("FAIL drain_order i%0d: got %0h want %0h", i, ift.out, DW'(i)); end
                end
                tick();
                n_checks++; if (irg.out !== rg_exp) begin n_errors++; $display("FAIL drain_rg p%0d i%0d: got %0h want %0h", pass, i, irg.out, rg_exp); end
            end
            drive(1'b0, 1'b0, '0);
            #1;
            n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty p%0d: got %b want 1 (push on full leaked)", pass, ift.empty); end
        end
    endtask

    task automatic test_registered();
        drive(1'b1, 1'b1, 4'd5); #1; tick();
        drive(1'b1, 1'b1, 4'd6); #1; tick();
        drive(1'b1, 1'b0, '0);   #1; tick();
        n_checks++; if (irg.out !== 4'd5) begin n_errors++; $display("FAIL reg_first_pop: got %0h want 5", irg.out); end
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL reg_hold c%0d: got %0h want %0h", i, irg.out, exp_rg()); end
        end
        drive(1'b1, 1'b0, '0);
        #1;
        n_checks++; if (irg.out !== 4'd5) begin n_errors++; $display("FAIL reg_before_second_pop: got %0h want 5", irg.out); end
        tick();
        n_checks++; if (irg.out !== 4'd6) begin n_errors++; $display("FAIL reg_second_pop: got %0h want 6", irg.out); end
        drive(1'b0, 1'b0, '0);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic e, w;
            int   bias;
            bias = (((i / 50) % 2) == 0) ? 75 : 25;
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 99) < bias);
            drive(e, w, DW'($urandom_range(0, 15)), AW'($urandom_range(0, SIZE - 1)));
            #1;
            n_checks++; if (ift.out !== exp_ft()) begin n_errors++; $display("FAIL rand_out_ft c%0d: got %0h want %0h", i, ift.out, exp_ft()); end
            n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL rand_out_rg c%0d: got %0h want %0h", i, irg.out, exp_rg()); end
            n_checks++; if (ift.empty !== (exp_q.size() == 0)) begin n_errors++; $display("FAIL rand_empty c%0d: got %b want %b", i, ift.empty, exp_q.size() == 0); end
            n_checks++; if (irg.full !== (exp_q.size() == SIZE)) begin n_errors++; $display("FAIL rand_full c%0d: got %b want %b", i, irg.full, exp_q.size() == SIZE); end
            tick();
        end
        drive(1'b0, 1'b0, '0);
        #1;
    endtask

    task automatic test_async_reset();
        while (exp_q.size() > 0) begin
            drive(1'b1, 1'b0, '0); #1; tick();
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, DW'(i + 3)); #1; tick();
        end
        drive(1'b0, 1'b0, '0);
        #1;
        n_checks++; if (ift.empty !== 1'b0) begin n_errors++; $display("FAIL arst_prefill_empty: got %b want 0", ift.empty); end
        // assert reset between clock edges
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL arst_empty_ft: got %b want 1", ift.empty); end
        n_checks++; if (irg.empty !== 1'b1) begin n_errors++; $display("FAIL arst_empty_rg: got %b want 1", irg.empty); end
        n_checks++; if (ift.out !== 4'd0) begin n_errors++; $display("FAIL arst_out_ft: got %0h want 0", ift.out); end
        n_checks++; if (irg.out !== 4'd0) begin n_errors++; $display("FAIL arst_out_rg: got %0h want 0", irg.out); end
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, '0);
        #1;
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        n_checks++; if (ift.empty !== 1'b1) begin n_errors++; $display("FAIL arst_pop_ignored: got %b want 1", ift.empty); end
        n_checks++; if (irg.out !== exp_rg()) begin n_errors++; $display("FAIL arst_pop_out_rg: got %0h want %0h", irg.out, exp_rg()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bypass();
        test_pop_to_empty();
        test_fill_full();
        test_registered();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus sequence itself ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t reached without completion", $time);
        $fatal(1);
    end
endmodule
